// File: rtl/alu_issue_stage_pkg.sv
// Shared definitions for the ALU issue stage: ALU operation codes, RV32 opcode and
// funct constants, and the skid buffer state encoding.
package alu_issue_stage_pkg;

    // The ALU decodes these same values.
    typedef enum logic [3:0] {
        ALU_AND  = 4'd0,
        ALU_XOR  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_ADD  = 4'd3,
        ALU_SUB  = 4'd4,
        ALU_MUL  = 4'd5,
        ALU_SRAI = 4'd6
    } alu_ctrl_e;

    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_SR  = 3'b101;
    localparam logic [2:0] F3_AND = 3'b111;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_FULL  = 2'd2
    } skid_state_e;

endpackage

// File: rtl/alu_issue_stage_if.sv
// Issue-stage bus: upstream instruction/operand handshake and downstream ALU
// control/operand handshake. The stage uses the slave modport.
interface alu_issue_stage_if #(
    parameter int XLEN = 32
);
    logic            flush_i;
    logic            in_valid_i;
    logic            in_ready_o;
    logic [31:0]     instr_i;
    logic [XLEN-1:0] rs1_data_i;
    logic [XLEN-1:0] rs2_data_i;
    logic            out_valid_o;
    logic            out_ready_i;
    logic [3:0]      alu_ctrl_o;
    logic [XLEN-1:0] data1_o;
    logic [XLEN-1:0] data2_o;
    logic [4:0]      rd_addr_o;
    logic            reg_write_o;
    logic            illegal_o;

    modport slave (
        input  flush_i, in_valid_i, instr_i, rs1_data_i, rs2_data_i, out_ready_i,
        output in_ready_o, out_valid_o, alu_ctrl_o, data1_o, data2_o,
               rd_addr_o, reg_write_o, illegal_o
    );

    modport master (
        output flush_i, in_valid_i, instr_i, rs1_data_i, rs2_data_i, out_ready_i,
        input  in_ready_o, out_valid_o, alu_ctrl_o, data1_o, data2_o,
               rd_addr_o, reg_write_o, illegal_o
    );
endinterface

// File: rtl/alu_issue_skid.sv
// Generic 2-entry valid/ready skid buffer over a packed payload. in_ready is a
// flop output; flush empties the buffer and wins over push and pop.
module alu_issue_skid
    import alu_issue_stage_pkg::*;
#(
    parameter int           W       = 8,
    parameter int           DEPTH   = 2,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    if (DEPTH != 2) begin : g_bad_depth
        $error("alu_issue_skid: DEPTH must be 2");
    end

    skid_state_e  state_q, state_d;
    logic [W-1:0] head_q, tail_q;
    logic         in_ready_q;
    logic         push, pop;
    logic         load_head, head_from_tail, load_tail;

    assign out_valid = (state_q != SKID_EMPTY);
    assign in_ready  = in_ready_q;
    assign out_data  = head_q;
    assign push      = in_valid & in_ready_q;
    assign pop       = out_valid & out_ready;

    // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d        = state_q;
        load_head      = 1'b0;
        head_from_tail = 1'b0;
        load_tail      = 1'b0;
        if (flush) begin
            state_d = SKID_EMPTY;
        end else begin
            case (state_q)
                SKID_EMPTY: begin
                    if (push) begin
                        state_d   = SKID_ONE;
                        load_head = 1'b1;
                    end
                end
                SKID_ONE: begin
                    // Push with pop: the new entry replaces the departing head.
                    case ({push, pop})
                        2'b10: begin
                            state_d   = SKID_FULL;
                            load_tail = 1'b1;
                        end
                        2'b01:   state_d   = SKID_EMPTY;
                        2'b11:   load_head = 1'b1;
                        default: ;
                    endcase
                end
                SKID_FULL: begin
                    if (pop) begin
                        state_d        = SKID_ONE;
                        head_from_tail = 1'b1;
                    end
                end
                default: state_d = SKID_EMPTY;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= SKID_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != SKID_FULL);
        end
    end

    // NOTE: the two entries are reset because the head drives the outputs directly and must show defined values out of reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            head_q <= RST_VAL;
            tail_q <= RST_VAL;
        end else begin
            if (load_head) begin
                head_q <= in_data;
            end else if (head_from_tail) begin
                head_q <= tail_q;
            end
            if (load_tail) begin
                tail_q <= in_data;
            end
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// RV32 decode into ALU control, operands and writeback info, registered through a
// 2-entry skid buffer. Define ALU_ISSUE_MUL_EN to decode MUL; otherwise it is illegal.
module alu_issue_stage
    import alu_issue_stage_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int SKID_DEPTH = 2
) (
    input logic               clk_i,
    input logic               rst_i,
    alu_issue_stage_if.slave  bus
);

    localparam int PW = 4 + 2 * XLEN + 5 + 2;
    localparam logic [PW-1:0] PAYLOAD_RST = {ALU_ADD, {(PW - 4){1'b0}}};

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rd;
    logic            legal;
    alu_ctrl_e       dec_ctrl;
    logic [XLEN-1:0] dec_data2;

    logic [3:0]      pl_ctrl;
    logic [XLEN-1:0] pl_data1, pl_data2;
    logic            pl_reg_write, pl_illegal;
    logic [PW-1:0]   in_payload, out_payload;
    logic            unused_rs1_addr;

    assign opcode = bus.instr_i[6:0];
    assign funct3 = bus.instr_i[14:12];
    assign funct7 = bus.instr_i[31:25];
    assign rd     = bus.instr_i[11:7];

    // The register file has already been read; the rs1 address field is not needed here.
    assign unused_rs1_addr = ^bus.instr_i[19:15];

    always_comb begin
        legal     = 1'b0;
        dec_ctrl  = ALU_ADD;
        dec_data2 = bus.rs2_data_i;
        case (opcode)
            OP_R: begin
                case ({funct7, funct3})
                    {F7_BASE, F3_AND}: begin legal = 1'b1; dec_ctrl = ALU_AND; end
                    {F7_BASE, F3_XOR}: begin legal = 1'b1; dec_ctrl = ALU_XOR; end
                    {F7_BASE, F3_SLL}: begin legal = 1'b1; dec_ctrl = ALU_SLL; end
                    {F7_BASE, F3_ADD}: begin legal = 1'b1; dec_ctrl = ALU_ADD; end
                    {F7_ALT,  F3_ADD}: begin legal = 1'b1; dec_ctrl = ALU_SUB; end
`ifdef ALU_ISSUE_MUL_EN
                    {F7_MULDIV, F3_ADD}: begin legal = 1'b1; dec_ctrl = ALU_MUL; end
`endif
                    default: ;
                endcase
            end
            OP_I: begin
                if (funct3 == F3_ADD) begin
                    legal     = 1'b1;
                    dec_ctrl  = ALU_ADD;
                    dec_data2 = {{(XLEN - 12){bus.instr_i[31]}}, bus.instr_i[31:20]};
                end else if (funct3 == F3_SR && funct7 == F7_ALT) begin
                    legal     = 1'b1;
                    dec_ctrl  = ALU_SRAI;
                    dec_data2 = {{(XLEN - 5){1'b0}}, bus.instr_i[24:20]};
                end
            end
            default: ;
        endcase
    end

    // Illegal entries still flow, but carry neutral control and zero operands.
    assign pl_illegal   = ~legal;
    assign pl_ctrl      = legal ? dec_ctrl : ALU_ADD;
    assign pl_data1     = legal ? bus.rs1_data_i : '0;
    assign pl_data2     = legal ? dec_data2 : '0;
    assign pl_reg_write = legal && (rd != 5'd0);

    assign in_payload = {pl_ctrl, pl_data1, pl_data2, rd, pl_reg_write, pl_illegal};

    alu_issue_skid #(
        .W       (PW),
        .DEPTH   (SKID_DEPTH),
        .RST_VAL (PAYLOAD_RST)
    ) u_skid (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .flush     (bus.flush_i),
        .in_valid  (bus.in_valid_i),
        .in_ready  (bus.in_ready_o),
        .in_data   (in_payload),
        .out_valid (bus.out_valid_o),
        .out_ready (bus.out_ready_i),
        .out_data  (out_payload)
    );

    assign {bus.alu_ctrl_o, bus.data1_o, bus.data2_o,
            bus.rd_addr_o, bus.reg_write_o, bus.illegal_o} = out_payload;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: decode vector table plus backpressure,
// push-and-pop, flush and asynchronous reset sequences.
module tb_alu_issue_stage;
    import alu_issue_stage_pkg::*;

    logic clk_i = 1'b0;
    logic rst_i;
    always #5 clk_i = ~clk_i;

    alu_issue_stage_if #(.XLEN(32)) bus ();

    alu_issue_stage #(.XLEN(32), .SKID_DEPTH(2)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [3:0]  ctrl;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [4:0]  rd;
        logic        rw;
        logic        ill;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] head_now();
        return 128'({bus.out_valid_o, bus.alu_ctrl_o, bus.data1_o, bus.data2_o,
                     bus.rd_addr_o, bus.reg_write_o, bus.illegal_o});
    endfunction

    function automatic logic [127:0] head_exp(input logic v, input logic [3:0] c,
                                              input logic [31:0] a, input logic [31:0] b,
                                              input logic [4:0] r, input logic w,
                                              input logic i);
        return 128'({v, c, a, b, r, w, i});
    endfunction

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] a,
                         input logic [31:0] b);
        bus.in_valid_i = v;
        bus.instr_i    = ins;
        bus.rs1_data_i = a;
        bus.rs2_data_i = b;
    endtask

    localparam logic [31:0] I_ADDI = 32'h00500093;  // addi x1,x0,5
    localparam logic [31:0] I_SUB  = 32'h402081B3;  // sub x3,x1,x2
    localparam logic [31:0] I_XOR  = 32'h00B544B3;  // xor x9,x10,x11

    initial begin
        vecs[0]  = '{"addi",      32'h00500093, 32'h0,        32'h0,        ALU_ADD,  32'h0,        32'h5,        5'd1,  1'b1, 1'b0};
        vecs[1]  = '{"sub",       32'h402081B3, 32'd10,       32'd3,        ALU_SUB,  32'd10,       32'd3,        5'd3,  1'b1, 1'b0};
        vecs[2]  = '{"srai",      32'h4030D293, 32'hFFFFFF00, 32'h12345678, ALU_SRAI, 32'hFFFFFF00, 32'd3,        5'd5,  1'b1, 1'b0};
`ifdef ALU_ISSUE_MUL_EN
        vecs[3]  = '{"mul",       32'h02208233, 32'd7,        32'd6,        ALU_MUL,  32'd7,        32'd6,        5'd4,  1'b1, 1'b0};
`else
        vecs[3]  = '{"mul",       32'h02208233, 32'd7,        32'd6,        ALU_ADD,  32'h0,        32'h0,        5'd4,  1'b0, 1'b1};
`endif
        vecs[4]  = '{"and",       32'h0083F333, 32'hF0F0F0F0, 32'h0FF00FF0, ALU_AND,  32'hF0F0F0F0, 32'h0FF00FF0, 5'd6,  1'b1, 1'b0};
        vecs[5]  = '{"xor",       32'h00B544B3, 32'h12345678, 32'h9ABCDEF0, ALU_XOR,  32'h12345678, 32'h9ABCDEF0, 5'd9,  1'b1, 1'b0};
        vecs[6]  = '{"sll",       32'h00E69633, 32'h00000001, 32'h0000001F, ALU_SLL,  32'h00000001, 32'h0000001F, 5'd12, 1'b1, 1'b0};
        vecs[7]  = '{"add_rd0",   32'h00208033, 32'h11111111, 32'h22222222, ALU_ADD,  32'h11111111, 32'h22222222, 5'd0,  1'b0, 1'b0};
        vecs[8]  = '{"addi_neg1", 32'hFFF08793, 32'h00000040, 32'h0,        ALU_ADD,  32'h00000040, 32'hFFFFFFFF, 5'd15, 1'b1, 1'b0};
        vecs[9]  = '{"addi_min",  32'h80008113, 32'h00000001, 32'h0,        ALU_ADD,  32'h00000001, 32'hFFFFF800, 5'd2,  1'b1, 1'b0};
        vecs[10] = '{"ill_load",  32'h0040A183, 32'hAAAAAAAA, 32'h55555555, ALU_ADD,  32'h0,        32'h0,        5'd3,  1'b0, 1'b1};
        vecs[11] = '{"ill_rfunc", 32'h40209233, 32'hAAAAAAAA, 32'h55555555, ALU_ADD,  32'h0,        32'h0,        5'd4,  1'b0, 1'b1};
        vecs[12] = '{"ill_srli",  32'h0030D293, 32'hAAAAAAAA, 32'h55555555, ALU_ADD,  32'h0,        32'h0,        5'd5,  1'b0, 1'b1};
        vecs[13] = '{"ill_slli",  32'h00109093, 32'hAAAAAAAA, 32'h55555555, ALU_ADD,  32'h0,        32'h0,        5'd1,  1'b0, 1'b1};

        rst_i           = 1'b1;
        bus.flush_i     = 1'b0;
        bus.out_ready_i = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 32'h0);
        #1 rst_i = 1'b0;
        #2;
        check("reset_head", head_now(), head_exp(1'b0, ALU_ADD, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0));
        check("reset_in_ready", 128'(bus.in_ready_o), 128'(1));
        @(negedge clk_i);
        rst_i = 1'b1;

        // Decode table: each instruction pushed alone, checked one cycle later, then popped.
        for (int i = 0; i < NV; i++) begin
            @(negedge clk_i);
            drive(1'b1, vecs[i].instr, vecs[i].rs1, vecs[i].rs2);
            @(negedge clk_i);
            drive(1'b0, 32'h0, 32'h0, 32'h0);
            check(vecs[i].name, head_now(),
                  head_exp(1'b1, vecs[i].ctrl, vecs[i].d1, vecs[i].d2,
                           vecs[i].rd, vecs[i].rw, vecs[i].ill));
        end
        @(negedge clk_i);
        check("drained", 128'({bus.out_valid_o, bus.in_ready_o}), 128'(2'b01));

        // Backpressure: fill to FULL, hold, then drain in order.
        bus.out_ready_i = 1'b0;
        drive(1'b1, I_ADDI, 32'h0, 32'h0);
        @(negedge clk_i);
        check("bp_one_ready", 128'(bus.in_ready_o), 128'(1));
        drive(1'b1, I_SUB, 32'd10, 32'd3);
        @(negedge clk_i);
        drive(1'b0, 32'h0, 32'h0, 32'h0);
        check("bp_full_ready", 128'(bus.in_ready_o), 128'(0));
        check("bp_full_head", head_now(), head_exp(1'b1, ALU_ADD, 32'h0, 32'h5, 5'd1, 1'b1, 1'b0));
        @(negedge clk_i);
        check("bp_hold_head", head_now(), head_exp(1'b1, ALU_ADD, 32'h0, 32'h5, 5'd1, 1'b1, 1'b0));
        bus.out_ready_i = 1'b1;
        @(negedge clk_i);
        check("bp_pop1_head", head_now(), head_exp(1'b1, ALU_SUB, 32'd10, 32'd3, 5'd3, 1'b1, 1'b0));
        check("bp_pop1_ready", 128'(bus.in_ready_o), 128'(1));
        @(negedge clk_i);
        check("bp_pop2_empty", 128'(bus.out_valid_o), 128'(0));

        // Push and pop together in ONE: the new entry becomes head.
        drive(1'b1, I_ADDI, 32'h0, 32'h0);
        @(negedge clk_i);
        drive(1'b1, I_SUB, 32'd10, 32'd3);
        @(negedge clk_i);
        drive(1'b0, 32'h0, 32'h0, 32'h0);
        check("pushpop_head", head_now(), head_exp(1'b1, ALU_SUB, 32'd10, 32'd3, 5'd3, 1'b1, 1'b0));
        check("pushpop_ready", 128'(bus.in_ready_o), 128'(1));
        @(negedge clk_i);
        check("pushpop_empty", 128'(bus.out_valid_o), 128'(0));

        // Flush in FULL with a concurrent push attempt.
        bus.out_ready_i = 1'b0;
        drive(1'b1, I_ADDI, 32'h0, 32'h0);
        @(negedge clk_i);
        drive(1'b1, I_SUB, 32'd10, 32'd3);
        @(negedge clk_i);
        bus.flush_i = 1'b1;
        drive(1'b1, I_XOR, 32'h1, 32'h2);
        @(negedge clk_i);
        bus.flush_i = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 32'h0);
        check("flush_full", 128'({bus.out_valid_o, bus.in_ready_o}), 128'(2'b01));
        bus.out_ready_i = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
        check("flush_full_stays_empty", 128'(bus.out_valid_o), 128'(0));

        // Flush in ONE while in_ready is high: the push must be discarded.
        bus.out_ready_i = 1'b0;
        drive(1'b1, I_ADDI, 32'h0, 32'h0);
        @(negedge clk_i);
        bus.flush_i = 1'b1;
        drive(1'b1, I_XOR, 32'h1, 32'h2);
        @(negedge clk_i);
        bus.flush_i = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 32'h0);
        check("flush_one_push_dropped", 128'({bus.out_valid_o, bus.in_ready_o}), 128'(2'b01));

        // Asynchronous reset mid-stream, sampled before the next rising edge.
        drive(1'b1, I_ADDI, 32'h0, 32'h0);
        @(negedge clk_i);
        drive(1'b1, I_SUB, 32'd10, 32'd3);
        @(negedge clk_i);
        drive(1'b0, 32'h0, 32'h0, 32'h0);
        check("pre_rst_full", 128'({bus.out_valid_o, bus.in_ready_o}), 128'(2'b10));
        #2 rst_i = 1'b0;
        #1;
        check("async_rst_head", head_now(), head_exp(1'b0, ALU_ADD, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0));
        check("async_rst_ready", 128'(bus.in_ready_o), 128'(1));
        @(negedge clk_i);
        rst_i = 1'b1;
        bus.out_ready_i = 1'b1;
        @(negedge clk_i);
        check("post_rst_empty", 128'(bus.out_valid_o), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
